// File: rtl/uart_pkg.sv
// Shared UART definitions: framer state encoding and line/parity levels,
// common to the TX framer and the RX path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte-request / serial-line bundle between a data source and the TX framer.
interface uart_tx_frame_if #(parameter int DATA_WIDTH = 8);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );

endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity bit for a data word; even (XOR) or odd (inverted XOR).
import uart_pkg::*;

module uart_parity_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, data LSB-first, optional parity, stop; one bit per CLK.
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit on the line
// DATA   | data bit cnt_q on the line
// PARITY | parity of the latched word on the line
// STOP   | stop bit; a pending Data_Valid chains straight into START
import uart_pkg::*;

module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_frame_if.slave    bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;
    logic                  pen_q, pen_nxt;
    logic                  ptyp_q, ptyp_nxt;
    logic                  tx_q, tx_nxt;
    logic                  busy_q, busy_nxt;
    logic                  accept;
    logic                  par_bit;

    uart_parity_calc #(.WIDTH(DATA_WIDTH)) u_parity (
        .data    (data_q),
        .par_typ (ptyp_q),
        .par_bit (par_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            data_q  <= data_nxt;
            pen_q   <= pen_nxt;
            ptyp_q  <= ptyp_nxt;
            tx_q    <= tx_nxt;
            busy_q  <= busy_nxt;
        end
    end

    // STOP lasts one cycle, so any STOP cycle is its final one.
    assign accept = bus.Data_Valid && (state_q == ST_IDLE || state_q == ST_STOP);

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        data_nxt  = data_q;
        pen_nxt   = pen_q;
        ptyp_nxt  = ptyp_q;

        case (state_q)
            ST_IDLE, ST_STOP: begin
                if (accept) begin
                    state_nxt = ST_START;
                    data_nxt  = bus.P_DATA;
                    pen_nxt   = bus.PAR_EN;
                    ptyp_nxt  = bus.PAR_TYP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                state_nxt = ST_DATA;
                cnt_nxt   = '0;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_nxt = pen_q ? ST_PARITY : ST_STOP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            ST_PARITY: state_nxt = ST_STOP;
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so TX_OUT and Busy leave flops.
    always_comb begin
        tx_nxt   = IDLE_LEVEL;
        busy_nxt = 1'b1;
        case (state_nxt)
            ST_IDLE:   busy_nxt = 1'b0;
            ST_START:  tx_nxt = START_BIT;
            ST_DATA:   tx_nxt = data_nxt[cnt_nxt];
            ST_PARITY: tx_nxt = par_bit;
            ST_STOP:   tx_nxt = STOP_BIT;
            default:   busy_nxt = 1'b0;
        endcase
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed scenarios plus randomized frames.
module tb_uart_tx_frame;

    localparam int DW = 8;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_frame #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference frame: bit i of the serial sequence for a given word/config.
    function automatic int frame_len(input bit pen);
        return DW + 2 + (pen ? 1 : 0);
    endfunction

    function automatic logic exp_bit(input logic [DW-1:0] d, input bit pen,
                                     input bit ptyp, input int i);
        int v;
        v = int'(d);
        if (i == 0)
            return 1'b0;
        if (i <= DW)
            return ((v >> (i - 1)) & 1) != 0;
        if (i == DW + 1 && pen)
            return (($countones(d) % 2) != 0) ^ ptyp;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx_idle"}, bus.TX_OUT, 1'b1);
        check({tag, "_busy_idle"}, bus.Busy, 1'b0);
    endtask

    task automatic issue(input logic [DW-1:0] d, input bit pen, input bit ptyp);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.Data_Valid = 1'b1;
        step();
    endtask

    // Checks a frame already accepted at the previous edge. Inputs are scrambled
    // every cycle to show they are latched; hold keeps Data_Valid high mid-frame.
    task automatic run_frame(input string tag, input logic [DW-1:0] d, input bit pen,
                             input bit ptyp, input bit hold, input int glitch_at,
                             input bit chain, input logic [DW-1:0] nd,
                             input bit npen, input bit nptyp);
        int len;
        len = frame_len(pen);
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_bit%0d", tag, i), bus.TX_OUT, exp_bit(d, pen, ptyp, i));
            check($sformatf("%s_busy%0d", tag, i), bus.Busy, 1'b1);
            bus.P_DATA     = DW'($urandom);
            bus.PAR_EN     = 1'($urandom);
            bus.PAR_TYP    = 1'($urandom);
            bus.Data_Valid = hold;
            if (i == glitch_at) begin
                bus.P_DATA     = '1;
                bus.Data_Valid = 1'b1;
            end
            if (i == len - 1) begin
                bus.Data_Valid = chain;
                if (chain) begin
                    bus.P_DATA  = nd;
                    bus.PAR_EN  = npen;
                    bus.PAR_TYP = nptyp;
                end
            end
            step();
        end
        if (!chain)
            check_idle({tag, "_end"});
    endtask

    initial begin
        logic [DW-1:0] d, nd;
        bit pen, ptyp, npen, nptyp, chain;
        int gap, glitch;

        bus.P_DATA     = 8'h5A;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b1;
        RST            = 1'b1;
        #2 RST = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_idle("reset_hold");
            step();
        end
        bus.Data_Valid = 1'b0;
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_idle("post_reset");
        end

        issue(8'hA5, 1'b0, 1'b0);
        run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, -1, 1'b0, '0, 1'b0, 1'b0);
        issue(8'hA5, 1'b1, 1'b0);
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, -1, 1'b0, '0, 1'b0, 1'b0);
        issue(8'hA5, 1'b1, 1'b1);
        run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b0, -1, 1'b0, '0, 1'b0, 1'b0);
        issue(8'h07, 1'b1, 1'b0);
        run_frame("07_even", 8'h07, 1'b1, 1'b0, 1'b0, -1, 1'b0, '0, 1'b0, 1'b0);

        issue(8'h3C, 1'b0, 1'b0);
        run_frame("3c_drop", 8'h3C, 1'b0, 1'b0, 1'b0, 3, 1'b0, '0, 1'b0, 1'b0);
        step();
        check_idle("3c_not_queued");

        issue(8'h55, 1'b0, 1'b0);
        run_frame("b2b_55", 8'h55, 1'b0, 1'b0, 1'b1, -1, 1'b1, 8'hAA, 1'b0, 1'b0);
        run_frame("b2b_aa", 8'hAA, 1'b0, 1'b0, 1'b1, -1, 1'b0, '0, 1'b0, 1'b0);

        // Abort during data bit 3 (frame index 4).
        issue(8'hC3, 1'b1, 1'b0);
        bus.Data_Valid = 1'b0;
        for (int i = 0; i < 4; i++)
            step();
        check("abort_bit3", bus.TX_OUT, exp_bit(8'hC3, 1'b1, 1'b0, 4));
        #2 RST = 1'b0;
        #1;
        check_idle("abort_async");
        step();
        check_idle("abort_held");
        RST = 1'b1;
        step();
        check_idle("abort_release");
        step();
        check_idle("abort_no_resume");
        issue(8'h81, 1'b0, 1'b0);
        run_frame("after_abort_81", 8'h81, 1'b0, 1'b0, 1'b0, -1, 1'b0, '0, 1'b0, 1'b0);

        d    = DW'($urandom);
        pen  = 1'($urandom);
        ptyp = 1'($urandom);
        issue(d, pen, ptyp);
        for (int k = 0; k < 40; k++) begin
            nd     = DW'($urandom);
            npen   = 1'($urandom);
            nptyp  = 1'($urandom);
            chain  = (k < 39) && ($urandom_range(0, 2) == 0);
            glitch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DW)) : -1;
            run_frame($sformatf("rnd%0d", k), d, pen, ptyp, 1'($urandom), glitch,
                      chain, nd, npen, nptyp);
            if (!chain && k < 39) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    bus.P_DATA = DW'($urandom);
                    step();
                    check_idle($sformatf("rnd%0d_gap", k));
                end
                issue(nd, npen, nptyp);
            end
            d    = nd;
            pen  = npen;
            ptyp = nptyp;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit framer: the transmit-side counterpart of the RX path. It accepts a parallel byte with a valid strobe and serializes it onto TX_OUT as start bit, data bits LSB-first, optional parity, then stop bit. It runs one bit per CLK cycle, so CLK is the TX baud clock. It sits between the system data source (FIFO or register interface) and the TX pin.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (must be ≥ 1)

Ports:
CLK  input  1  TX baud clock; all logic on rising edge
RST  input  1  asynchronous, active-low reset
P_DATA  input  DATA_WIDTH  parallel data to transmit; sampled only on acceptance
Data_Valid  input  1  request to send P_DATA; single-cycle or level
PAR_EN  input  1  1 = parity bit inserted after data bits
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line, registered; idles high
Busy  output  1  registered; 1 while a frame is on the line

Behaviour:
- Reset (RST low, async): state=IDLE, TX_OUT=1, Busy=0, data latch=0, bit counter=0.
- States: IDLE, START, DATA, PARITY, STOP. Encoding one-hot or binary; it must not be visible at any output.
- Acceptance:
  - Occurs at a rising edge where Data_Valid=1 and (state=IDLE, or state=STOP on its final cycle).
  - P_DATA, PAR_EN and PAR_TYP are latched internally at that edge.
  - Later changes on these inputs do not affect the frame in flight.
- Latency: after the accepting edge, TX_OUT=0 (start bit) and Busy=1. Zero extra cycles.
- START, 1 cycle: TX_OUT=0, then go to DATA with counter=0.
- DATA, DATA_WIDTH cycles:
  - TX_OUT=latched_data[counter], so LSB goes first.
  - After counter=DATA_WIDTH-1: go to PARITY if latched PAR_EN, else go to STOP.
- PARITY, 1 cycle:
  - TX_OUT = XOR of latched data bits when PAR_TYP=0.
  - TX_OUT = inverted XOR when PAR_TYP=1.
  - Parity is computed from latched data, never from live P_DATA.
- STOP, 1 cycle: TX_OUT=1.
  - At the next edge: if Data_Valid=1, accept a new frame and go to START (Busy stays 1, no idle gap).
  - Otherwise go to IDLE with Busy=0 and TX_OUT=1.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
- Data_Valid=1 in START, DATA or PARITY is ignored and not queued. The upstream source must hold or re-assert until Busy falls or the stop cycle ends.
- TX_OUT comes straight from a flop (no combinational path to the pin), so the line is glitch-free.
- Reset mid-frame: TX_OUT returns high immediately (async) and the frame is abandoned. There is no resume after RST deasserts.
- No X propagation: undefined states return to IDLE with TX_OUT=1.

Decomposition:
- Shared package (uart_pkg):
  - state encoding constants for IDLE/START/DATA/PARITY/STOP
  - PAR_EVEN=0, PAR_ODD=1
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1
  - These are reused by the RX side.
- One natural sub-module, uart_parity_calc: combinational. Inputs are the data word and type; output is the parity bit. The same module serves the RX parity checker.
- FSM, bit counter, data latch and output mux stay in uart_tx_frame.

Test Plan:
- Reset: hold RST low with Data_Valid=1 → TX_OUT=1, Busy=0. Release RST with Data_Valid=0 → remains idle for 20 cycles.
- P_DATA=0xA5, PAR_EN=0, single-cycle Data_Valid → TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1. Busy=1 for exactly 10 cycles, then 0.
- P_DATA=0xA5 with PAR_EN=1:
  - PAR_TYP=0 → parity bit 0, 11-cycle frame.
  - PAR_TYP=1 → parity bit 1.
  - P_DATA=0x07 with PAR_TYP=0 → parity bit 1.
- Change P_DATA to 0xFF and pulse Data_Valid during the DATA state of a 0x3C frame → line carries 0x3C unchanged. The second request is dropped, and Busy falls after the stop bit.
- Hold Data_Valid=1 continuously, with P_DATA=0x55 then 0xAA → two back-to-back frames. The stop bit is immediately followed by a start bit, and Busy never drops between frames.
- Assert RST during data bit 3 of a frame → TX_OUT=1 and Busy=0 asynchronously. A new 0x81 request after release produces a clean full frame.
